// File: rtl/sdram_slot_pkg.sv
`default_nettype none
// ============================================================
// sdram_slot_pkg : owner encoding and default parameters for the slot arbiter
// Rev 1.0
// ============================================================
package sdram_slot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHIP    = 3'd1,
        RTG     = 3'd2,
        AUD     = 3'd3,
        CPU     = 3'd4,
        HOST    = 3'd5,
        REFRESH = 3'd6
    } owner_e;

    localparam int DEF_SLOT_LEN         = 16;
    localparam int DEF_REFRESH_INTERVAL = 890;
    localparam int DEF_CPU_MAX_WAIT     = 4;
    localparam int DEF_CHIP_MAX_DEFER   = 2;

    // Ack bit order: {host, cpu, aud, rtg, chip}; IDLE and REFRESH never ack.
    function automatic logic [4:0] ack_mask(input owner_e owner);
        logic [4:0] mask;
        mask = 5'b00000;
        case (owner)
            CHIP:    mask = 5'b00001;
            RTG:     mask = 5'b00010;
            AUD:     mask = 5'b00100;
            CPU:     mask = 5'b01000;
            HOST:    mask = 5'b10000;
            default: mask = 5'b00000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_slot_arbiter_if.sv
`default_nettype none
// ============================================================
// sdram_slot_arbiter_if : requester handshakes and slot status of the arbiter
// Rev 1.0
// ============================================================
interface sdram_slot_arbiter_if
    import sdram_slot_pkg::*;
#(
    parameter int SLOT_LEN = DEF_SLOT_LEN
);
    logic                        chip_req;
    logic                        rtg_req;
    logic                        aud_req;
    logic                        cpu_req;
    logic                        host_req;
    logic                        chip_ack;
    logic                        rtg_ack;
    logic                        aud_ack;
    logic                        cpu_ack;
    logic                        host_ack;
    owner_e                      grant;
    logic [$clog2(SLOT_LEN)-1:0] slot_phase;
    logic                        slot_start;
    logic                        refresh_overrun;

    modport master (
        input  chip_req, rtg_req, aud_req, cpu_req, host_req,
        output chip_ack, rtg_ack, aud_ack, cpu_ack, host_ack,
        output grant, slot_phase, slot_start, refresh_overrun
    );

    modport slave (
        output chip_req, rtg_req, aud_req, cpu_req, host_req,
        input  chip_ack, rtg_ack, aud_ack, cpu_ack, host_ack,
        input  grant, slot_phase, slot_start, refresh_overrun
    );

endinterface
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// ============================================================
// sdram_refresh_timer : refresh interval counter with pending and sticky overrun flags
// Rev 1.0
// ============================================================
module sdram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 890
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic refresh_taken,
    output logic pending,
    output logic overrun
);
    localparam int            CW     = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

    logic [CW-1:0] count_q, count_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          expire;

    // A grant and an expiry in the same cycle leave a fresh request pending.
    always_comb begin
        expire    = (count_q == '0);
        count_d   = expire ? RELOAD : (count_q - CW'(1));
        pending_d = expire | (pending_q & ~refresh_taken);
        overrun_d = overrun_q | (expire & pending_q & ~refresh_taken);
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: rtl/sdram_slot_arbiter.sv
`default_nettype none
// ============================================================
// sdram_slot_arbiter : grants fixed-length SDRAM slots to one requester or refresh
// Rev 1.0
// ============================================================
module sdram_slot_arbiter
    import sdram_slot_pkg::*;
#(
    parameter int SLOT_LEN         = DEF_SLOT_LEN,
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int CPU_MAX_WAIT     = DEF_CPU_MAX_WAIT,
    parameter int CHIP_MAX_DEFER   = DEF_CHIP_MAX_DEFER
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    sdram_slot_arbiter_if.master bus
);
    localparam int            PW         = $clog2(SLOT_LEN);
    localparam logic [PW-1:0] PH_LAST    = PW'(SLOT_LEN - 1);
    localparam logic [PW-1:0] PH_ACK_PRE = PW'(SLOT_LEN - 3);
    localparam int            WW         = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(CPU_MAX_WAIT);
    localparam int            DW         = $clog2(CHIP_MAX_DEFER + 1);
    localparam logic [DW-1:0] DEFER_MAX  = DW'(CHIP_MAX_DEFER);

    logic [PW-1:0] phase_q, phase_d;
    owner_e        grant_q, grant_d;
    logic [4:0]    ack_q, ack_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [DW-1:0] defer_q, defer_d;

    owner_e winner;
    logic   decide;
    logic   refresh_taken;
    logic   refresh_pending;
    logic   refresh_overrun;
    logic   cpu_starved;
    logic   chip_must_yield;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .sysclk        (sysclk),
        .reset_n       (reset_n),
        .refresh_taken (refresh_taken),
        .pending       (refresh_pending),
        .overrun       (refresh_overrun)
    );

    always_comb begin
        cpu_starved     = (wait_q >= WAIT_MAX);
        chip_must_yield = refresh_pending && (defer_q >= DEFER_MAX);

        winner = IDLE;
        if (chip_must_yield)                winner = REFRESH;
        else if (bus.chip_req)              winner = CHIP;
        else if (refresh_pending)           winner = REFRESH;
        else if (bus.cpu_req && cpu_starved) winner = CPU;
        else if (bus.aud_req)               winner = AUD;
        else if (bus.rtg_req)               winner = RTG;
        else if (bus.cpu_req)               winner = CPU;
        else if (bus.host_req)              winner = HOST;

        decide        = (phase_q == PH_LAST);
        refresh_taken = decide && (winner == REFRESH);
    end

    always_comb begin
        phase_d = phase_q + PW'(1);
        grant_d = decide ? winner : grant_q;
        // Registered one cycle early so the pulse lands on phase SLOT_LEN-2.
        ack_d   = (phase_q == PH_ACK_PRE) ? ack_mask(grant_q) : 5'b00000;

        wait_d = wait_q;
        if (decide) begin
            if (!bus.cpu_req || (winner == CPU)) wait_d = '0;
            else if (wait_q != WAIT_MAX)         wait_d = wait_q + WW'(1);
        end

        defer_d = defer_q;
        if (decide) begin
            if (winner == REFRESH)
                defer_d = '0;
            else if ((winner == CHIP) && refresh_pending && (defer_q != DEFER_MAX))
                defer_d = defer_q + DW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            grant_q <= IDLE;
            ack_q   <= 5'b00000;
            wait_q  <= '0;
            defer_q <= '0;
        end else begin
            phase_q <= phase_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            wait_q  <= wait_d;
            defer_q <= defer_d;
        end
    end

    assign bus.grant           = grant_q;
    assign bus.slot_phase      = phase_q;
    assign bus.slot_start      = (phase_q == '0);
    assign bus.chip_ack        = ack_q[0];
    assign bus.rtg_ack         = ack_q[1];
    assign bus.aud_ack         = ack_q[2];
    assign bus.cpu_ack         = ack_q[3];
    assign bus.host_ack        = ack_q[4];
    assign bus.refresh_overrun = refresh_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sdram_slot_arbiter.sv
`default_nettype none
// ============================================================
// tb_sdram_slot_arbiter : slot-by-slot scoreboard check of grants, acks and refresh
// Rev 1.0
// ============================================================
module tb_sdram_slot_arbiter;
    import sdram_slot_pkg::*;

    typedef struct {
        logic [4:0] req;   // {host, cpu, aud, rtg, chip} seen at the decision
        owner_e     exp;   // owner of the following slot
        int         reps;
    } vec_t;

    logic sysclk = 1'b0;
    logic reset_n;
    always #5 sysclk = ~sysclk;

    sdram_slot_arbiter_if #(.SLOT_LEN(16)) bus ();
    sdram_slot_arbiter_if #(.SLOT_LEN(16)) bus_ovr ();

    sdram_slot_arbiter #(
        .SLOT_LEN(16), .REFRESH_INTERVAL(890), .CPU_MAX_WAIT(4), .CHIP_MAX_DEFER(2)
    ) dut (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    sdram_slot_arbiter #(
        .SLOT_LEN(16), .REFRESH_INTERVAL(20), .CPU_MAX_WAIT(4), .CHIP_MAX_DEFER(8)
    ) dut_ovr (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .bus     (bus_ovr)
    );

    vec_t   vt [0:21];
    owner_e exp_q [$];
    owner_e cur;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [4:0] exp_ack(input owner_e o);
        case (o)
            CHIP:    return 5'b00001;
            RTG:     return 5'b00010;
            AUD:     return 5'b00100;
            CPU:     return 5'b01000;
            HOST:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] act_ack();
        return {bus.host_ack, bus.cpu_ack, bus.aud_ack, bus.rtg_ack, bus.chip_ack};
    endfunction

    task automatic drive_req(input logic [4:0] r);
        bus.chip_req = r[0];
        bus.rtg_req  = r[1];
        bus.aud_req  = r[2];
        bus.cpu_req  = r[3];
        bus.host_req = r[4];
    endtask

    task automatic next_cycle();
        @(negedge sysclk);
        cyc++;
    endtask

    task automatic do_reset(input logic [4:0] r);
        reset_n = 1'b0;
        drive_req(r);
        #1;
        chk("rst_grant", bus.grant, IDLE);
        chk("rst_phase", bus.slot_phase, 0);
        chk("rst_slot_start", bus.slot_start, 1);
        chk("rst_overrun", bus.refresh_overrun, 0);
        chk("rst_ovr_overrun", bus_ovr.refresh_overrun, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            chk("rst_ack", act_ack(), 0);
            chk("rst_grant_hold", bus.grant, IDLE);
        end
        reset_n = 1'b1;
        cyc = 0;
        exp_q.delete();
        exp_q.push_back(IDLE);
    endtask

    // One full slot starting at phase 0; drives the next decision's requests at phase 15.
    task automatic run_one_slot(input logic [4:0] r, input owner_e e);
        for (int p = 0; p < 16; p++) begin
            if (p == 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty cyc=%0d actual=empty expected=entry", cyc);
                    cur = IDLE;
                end else begin
                    cur = exp_q.pop_front();
                end
                chk("grant", bus.grant, cur);
            end
            chk("slot_start", bus.slot_start, (p == 0) ? 32'd1 : 32'd0);
            chk("slot_phase", bus.slot_phase, p);
            chk("ack", act_ack(), (p == 14) ? exp_ack(cur) : 5'b00000);
            if (p == 15) begin
                drive_req(r);
                exp_q.push_back(e);
            end
            next_cycle();
        end
    endtask

    task automatic run_group(input int first, input int last);
        for (int i = first; i <= last; i++)
            for (int k = 0; k < vt[i].reps; k++)
                run_one_slot(vt[i].req, vt[i].exp);
    endtask

    initial begin
        // basic single CPU request
        vt[0]  = '{5'b01000, CPU,     1};
        vt[1]  = '{5'b00000, IDLE,    1};
        // fixed priority
        vt[2]  = '{5'b11111, CHIP,    1};
        vt[3]  = '{5'b11010, RTG,     1};
        vt[4]  = '{5'b11000, CPU,     1};
        vt[5]  = '{5'b01100, AUD,     1};
        vt[6]  = '{5'b10000, HOST,    1};
        vt[7]  = '{5'b00000, IDLE,    1};
        // CPU starvation promotion over AUD
        vt[8]  = '{5'b01100, AUD,     4};
        vt[9]  = '{5'b01100, CPU,     1};
        vt[10] = '{5'b01100, AUD,     1};
        vt[11] = '{5'b00000, IDLE,    1};
        // AUD/RTG/HOST each drop after their ack
        vt[12] = '{5'b10110, AUD,     1};
        vt[13] = '{5'b10010, RTG,     1};
        vt[14] = '{5'b10000, HOST,    1};
        vt[15] = '{5'b00000, IDLE,    1};
        // chip held; refresh pending from cycle 890, served on the third pending decision
        vt[16] = '{5'b00001, CHIP,    57};
        vt[17] = '{5'b00001, REFRESH, 1};
        vt[18] = '{5'b00001, CHIP,    4};
        vt[19] = '{5'b00000, IDLE,    1};
        // after mid-slot reset
        vt[20] = '{5'b01000, CPU,     1};
        vt[21] = '{5'b00000, IDLE,    1};

        cur = IDLE;
        bus_ovr.chip_req = 1'b1;
        bus_ovr.rtg_req  = 1'b0;
        bus_ovr.aud_req  = 1'b0;
        bus_ovr.cpu_req  = 1'b0;
        bus_ovr.host_req = 1'b0;

        // Short refresh interval: second expiry at cycle 39 finds refresh still pending.
        do_reset(5'b00000);
        for (int c = 0; c < 150; c++) begin
            if (c == 16 || c == 32) chk("ovr_grant", bus_ovr.grant, CHIP);
            chk("ovr_overrun", bus_ovr.refresh_overrun, (c >= 40) ? 32'd1 : 32'd0);
            next_cycle();
        end

        do_reset(5'b01000);
        run_group(0, 15);

        do_reset(5'b00001);
        run_group(16, 19);
        chk("main_overrun", bus.refresh_overrun, 0);

        // Reset at phase 10 of a CPU slot: the pending ack must never appear.
        do_reset(5'b01000);
        run_one_slot(5'b01000, CPU);
        for (int p = 0; p < 10; p++) begin
            if (p == 0) begin
                cur = exp_q.pop_front();
                chk("pre_rst_grant", bus.grant, cur);
            end
            chk("pre_rst_ack", act_ack(), 0);
            next_cycle();
        end
        chk("pre_rst_phase", bus.slot_phase, 10);
        chk("pre_rst_grant_hold", bus.grant, CPU);
        do_reset(5'b01000);
        run_one_slot(5'b01000, CPU);
        run_group(20, 21);
        run_one_slot(5'b00000, IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
